// File: rtl/cla_slice_seq_pkg.sv
// rtl/cla_slice_seq_pkg.sv - shared constants and state encoding for the byte-serial add/sub sequencer
package cla_slice_seq_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_slice_seq_cla8.sv
// rtl/cla_slice_seq_cla8.sv - 8-bit carry-lookahead adder slice
module cla_slice_seq_cla8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] f,
    output logic       cout
);

    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       acc;
    logic       pp;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is the flattened sum-of-products over all lower generate/propagate
    // terms, so no carry depends on another carry.
    always_comb begin
        c    = '0;
        acc  = 1'b0;
        pp   = 1'b0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            acc      = acc | (pp & cin);
            c[i + 1] = acc;
        end
    end

    assign f    = p ^ c[7:0];
    assign cout = c[8];

endmodule

// File: rtl/cla_slice_seq.sv
// rtl/cla_slice_seq.sv - byte-serial add/subtract sequencer time-sharing one CLA8 slice
module cla_slice_seq
    import cla_slice_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = $clog2(NSLICE);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic               creg;
    logic [IDX_W-1:0]   idx;
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_f;
    logic               slice_cout;
    logic               last;
    logic               accept;

    assign in_ready  = (state == ST_IDLE) && !rst;
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (idx == IDX_W'(NSLICE - 1));

    assign slice_a = opa[int'(idx) * SLICE_W +: SLICE_W];
    assign slice_b = opb[int'(idx) * SLICE_W +: SLICE_W];

    cla_slice_seq_cla8 u_cla8 (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (creg),
        .f    (slice_f),
        .cout (slice_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)    state_nxt = ST_BUSY;
            ST_BUSY: if (last)      state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    // Subtract is A + ~B + 1: operand B is inverted once at accept and the +1 enters as cin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa      <= '0;
            opb      <= '0;
            creg     <= 1'b0;
            idx      <= '0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        opa  <= a;
                        opb  <= b ^ {WIDTH{sub}};
                        creg <= sub;
                        idx  <= '0;
                    end
                end
                ST_BUSY: begin
                    result[int'(idx) * SLICE_W +: SLICE_W] <= slice_f;
                    creg <= slice_cout;
                    idx  <= idx + 1'b1;
                    if (last) begin
                        carry    <= slice_cout;
                        overflow <= (opa[WIDTH-1] == opb[WIDTH-1]) &&
                                    (slice_f[SLICE_W-1] != opa[WIDTH-1]);
                        // Lower bytes are already in result; only the top byte is still in flight.
                        zero     <= (slice_f == '0) &&
                                    (result[WIDTH-SLICE_W-1:0] == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_slice_seq.sv
// tb/tb_cla_slice_seq.sv - directed self-checking bench for cla_slice_seq
module tb_cla_slice_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        carry;
    logic        overflow;
    logic        zero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cla_slice_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                             input logic sv);
        check({tag, ".in_ready_pre"}, 32'(in_ready), 32'd1);
        a        = av;
        b        = bv;
        sub      = sv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
    endtask

    task automatic wait_done(input string tag, input bit scramble);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            if (scramble) begin
                a   = $urandom;
                b   = $urandom;
                sub = 1'($urandom);
            end
            tick();
            n++;
        end
        check({tag, ".latency"}, 32'(n), 32'd4);
    endtask

    task automatic check_out(input string tag, input logic [31:0] res, input logic c,
                             input logic v, input logic z);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".result"},    result,         res);
        check({tag, ".carry"},     32'(carry),     32'(c));
        check({tag, ".overflow"},  32'(overflow),  32'(v));
        check({tag, ".zero"},      32'(zero),      32'(z));
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".out_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, ".in_ready_back"},  32'(in_ready),  32'd1);
    endtask

    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic sv, input bit scramble, input logic [31:0] res,
                          input logic c, input logic v, input logic z);
        accept_op(tag, av, bv, sv);
        wait_done(tag, scramble);
        check_out(tag, res, c, v, z);
        release_out(tag);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        #23;
        check("rst.in_ready",  32'(in_ready),  32'd0);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.result",    result,         32'd0);
        check("rst.flags",     {29'd0, carry, overflow, zero}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rst.in_ready_release", 32'(in_ready), 32'd1);

        run_op("add_ff_1",   32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        run_op("add_wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_op("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_op("sub_neg",    32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_op("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        run_op("sub_eq",     32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

        // Backpressure: hold DONE with a competing request and wiggling operands.
        accept_op("bp", 32'h0000_0010, 32'h0000_0020, 1'b0);
        wait_done("bp", 1'b0);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            b = $urandom;
            tick();
            check("bp.hold_valid",  32'(out_valid), 32'd1);
            check("bp.hold_ready",  32'(in_ready),  32'd0);
            check("bp.hold_result", result,         32'h0000_0030);
        end
        a         = 32'h0000_0100;
        b         = 32'h0000_0200;
        sub       = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp.idle_valid", 32'(out_valid), 32'd0);
        check("bp.idle_ready", 32'(in_ready),  32'd1);
        tick();
        in_valid = 1'b0;
        check("bp.second_accept", 32'(in_ready), 32'd0);
        wait_done("bp2", 1'b0);
        check_out("bp2", 32'h0000_0300, 1'b0, 1'b0, 1'b0);
        release_out("bp2");

        run_op("scramble", 32'h0102_0304, 32'h1020_3040, 1'b0, 1'b1, 32'h1122_3344, 1'b0, 1'b0, 1'b0);

        // Abort while the third byte (idx==2) is being processed.
        accept_op("abort", 32'h1234_5678, 32'h1111_1111, 1'b0);
        tick();
        tick();
        check("abort.partial", result & 32'h0000_FFFF, 32'h0000_6789);
        #3;
        rst = 1'b1;
        #1;
        check("abort.out_valid", 32'(out_valid), 32'd0);
        check("abort.result",    result,         32'd0);
        check("abort.flags",     {29'd0, carry, overflow, zero}, 32'd0);
        check("abort.in_ready",  32'(in_ready),  32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("abort.in_ready_release", 32'(in_ready), 32'd1);
        tick();
        check("abort.still_idle", 32'(out_valid), 32'd0);
        run_op("after_abort", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
